spi_minion_adapter_mc: RTL and testbench

Multi-channel successor to the single-channel SPI minion adapter. Bridges the SPI minion push/pull packet interface to num_channels independent val/rdy channel pairs. Each SPI data word carries a channel address plus payload. Writes are steered to per-channel minion→chip queues. Reads are served from per-channel chip→minion queues through a round-robin arbiter, and the winning channel id is returned in the pulled word.

---
 rtl/spi_adapter_pkg.sv | 19 +
 rtl/spi_adapter_rr_arb.sv | 48 ++++
 rtl/vc_queue.sv | 67 ++++++
 rtl/spi_minion_adapter_mc.sv | 122 ++++++++++++
 tb/tb_spi_minion_adapter_mc.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/spi_adapter_pkg.sv
// Shared sizing helpers for the multi-channel SPI minion adapter.
// The payload is what remains of the data field after the channel address.
package spi_adapter_pkg;

  localparam int ERR_CNT_W = 8;

  function automatic int calc_addr_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int calc_pw(input int nbits, input int n);
    return nbits - 2 - calc_addr_bits(n);
  endfunction

  function automatic int chan_lo(input int ch, input int pw);
    return ch * pw;
  endfunction

endpackage

// File: rtl/spi_adapter_rr_arb.sv
// Round-robin arbiter: searches upward from the pointer with wrap; the pointer
// moves past the winner only when en is asserted and something was granted.
module spi_adapter_rr_arb
  import spi_adapter_pkg::*;
#(
  parameter int num_channels = 4,
  localparam int ID_W        = calc_addr_bits(num_channels)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [num_channels-1:0] req,
  input  logic                    en,
  output logic [num_channels-1:0] grant_onehot,
  output logic [ID_W-1:0]         grant_id
);

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic            found;

  always_comb begin
    int idx;
    idx      = 0;
    found    = 1'b0;
    grant_id = '0;
    for (int k = 0; k < num_channels; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= num_channels) idx = idx - num_channels;
      if (!found && req[idx]) begin
        found    = 1'b1;
        grant_id = ID_W'(idx);
      end
    end
  end

  assign grant_onehot = found ? (num_channels'(1) << grant_id) : '0;

  always_comb begin
    ptr_d = ptr_q;
    if (en && found)
      ptr_d = (grant_id == ID_W'(num_channels - 1)) ? '0 : grant_id + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/vc_queue.sv
// Normal (non-bypass) circular queue: an enqueued word becomes visible one cycle later.
// enq_rdy depends only on occupancy, so a full queue never accepts in the same cycle it drains.
module vc_Queue #(
  parameter int p_msg_nbits = 8,
  parameter int p_num_msgs  = 2,
  localparam int CNT_W      = $clog2(p_num_msgs + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enq_val,
  output logic                   enq_rdy,
  input  logic [p_msg_nbits-1:0] enq_msg,
  output logic                   deq_val,
  input  logic                   deq_rdy,
  output logic [p_msg_nbits-1:0] deq_msg,
  output logic [CNT_W-1:0]       num_free_entries
);

  localparam int PTR_W = (p_num_msgs > 1) ? $clog2(p_num_msgs) : 1;

  logic [p_msg_nbits-1:0] mem_q [p_num_msgs];
  logic [PTR_W-1:0]       head_q, head_d;
  logic [PTR_W-1:0]       tail_q, tail_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   enq_fire, deq_fire;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(p_num_msgs - 1)) ? '0 : p + 1'b1;
  endfunction

  assign enq_rdy          = (count_q != CNT_W'(p_num_msgs));
  assign deq_val          = (count_q != '0);
  assign deq_msg          = mem_q[head_q];
  assign num_free_entries = CNT_W'(p_num_msgs) - count_q;
  assign enq_fire         = enq_val & enq_rdy;
  assign deq_fire         = deq_val & deq_rdy;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (enq_fire) tail_d = next_ptr(tail_q);
    if (deq_fire) head_d = next_ptr(head_q);
    case ({enq_fire, deq_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq_fire) mem_q[tail_q] <= enq_msg;
  end

endmodule

// File: rtl/spi_minion_adapter_mc.sv
// Multi-channel SPI minion adapter: addressed writes fan out to per-channel queues,
// reads are arbitrated round-robin. Define SPI_MINION_ADAPTER_MC_ERRCNT_EN for drop counting.
module spi_minion_adapter_mc
  import spi_adapter_pkg::*;
#(
  parameter int nbits        = 34,
  parameter int num_entries  = 2,
  parameter int num_channels = 4,
  localparam int ADDR_BITS   = calc_addr_bits(num_channels),
  localparam int PW          = calc_pw(nbits, num_channels)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_en,
  input  logic                       push_msg_val_wrt,
  input  logic                       push_msg_val_rd,
  input  logic [nbits-3:0]           push_msg_data,
  input  logic                       pull_en,
  output logic                       pull_msg_val,
  output logic                       pull_msg_spc,
  output logic [nbits-3:0]           pull_msg_data,
  input  logic [num_channels*PW-1:0] recv_msg,
  input  logic [num_channels-1:0]    recv_val,
  output logic [num_channels-1:0]    recv_rdy,
  output logic [num_channels*PW-1:0] send_msg,
  output logic [num_channels-1:0]    send_val,
  input  logic [num_channels-1:0]    send_rdy,
  output logic [num_channels-1:0]    parity
`ifdef SPI_MINION_ADAPTER_MC_ERRCNT_EN
  ,
  output logic [ERR_CNT_W-1:0]       err_cnt,
  output logic                       err_flag
`endif
);

  localparam int FREE_W = $clog2(num_entries + 1);

  logic                    wr_strobe, rd_strobe;
  logic [ADDR_BITS-1:0]    wr_addr;
  logic [PW-1:0]           wr_payload;
  logic [num_channels-1:0] wr_ch, mc_rdy, spc_ch, cm_val, grant_onehot;
  logic [FREE_W-1:0]       mc_free [num_channels];
  logic [FREE_W-1:0]       unused_cm_free [num_channels];
  logic [PW-1:0]           cm_msg [num_channels];
  logic [ADDR_BITS-1:0]    grant_id;

  assign wr_strobe  = push_en & push_msg_val_wrt;
  assign rd_strobe  = push_en & push_msg_val_rd & pull_en;
  assign wr_addr    = push_msg_data[nbits-3 -: ADDR_BITS];
  assign wr_payload = push_msg_data[PW-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < num_channels; gi++) begin : g_chan
      // Out-of-range addresses match no channel, so they fall through as drops.
      assign wr_ch[gi] = wr_strobe & (wr_addr == ADDR_BITS'(gi));

      vc_Queue #(.p_msg_nbits(PW), .p_num_msgs(num_entries)) u_mc_q (
        .clk              (clk),
        .reset            (reset),
        .enq_val          (wr_ch[gi]),
        .enq_rdy          (mc_rdy[gi]),
        .enq_msg          (wr_payload),
        .deq_val          (send_val[gi]),
        .deq_rdy          (send_rdy[gi]),
        .deq_msg          (send_msg[chan_lo(gi, PW) +: PW]),
        .num_free_entries (mc_free[gi])
      );

      vc_Queue #(.p_msg_nbits(PW), .p_num_msgs(num_entries)) u_cm_q (
        .clk              (clk),
        .reset            (reset),
        .enq_val          (recv_val[gi]),
        .enq_rdy          (recv_rdy[gi]),
        .enq_msg          (recv_msg[chan_lo(gi, PW) +: PW]),
        .deq_val          (cm_val[gi]),
        .deq_rdy          (rd_strobe & grant_onehot[gi]),
        .deq_msg          (cm_msg[gi]),
        .num_free_entries (unused_cm_free[gi])
      );

      // Conservative: the next write could target any channel.
      assign spc_ch[gi] = mc_rdy[gi] & (~wr_ch[gi] | (mc_free[gi] > FREE_W'(1)));
      assign parity[gi] = (^send_msg[chan_lo(gi, PW) +: PW]) & send_val[gi];
    end
  endgenerate

  spi_adapter_rr_arb #(.num_channels(num_channels)) u_arb (
    .clk          (clk),
    .reset        (reset),
    .req          (cm_val),
    .en           (rd_strobe),
    .grant_onehot (grant_onehot),
    .grant_id     (grant_id)
  );

  assign pull_msg_spc  = &spc_ch;
  assign pull_msg_val  = rd_strobe & (|cm_val);
  assign pull_msg_data = pull_msg_val ? {grant_id, cm_msg[grant_id]} : '0;

`ifdef SPI_MINION_ADAPTER_MC_ERRCNT_EN
  logic                 drop;
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic                 err_flag_q;

  assign drop = wr_strobe & ~(|(wr_ch & mc_rdy));

  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt_q  <= '0;
      err_flag_q <= 1'b0;
    end else if (drop) begin
      if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
      err_flag_q <= 1'b1;
    end
  end

  assign err_cnt  = err_cnt_q;
  assign err_flag = err_flag_q;
`endif

endmodule

// File: tb/tb_spi_minion_adapter_mc.sv
// Directed bench for spi_minion_adapter_mc: a 4-channel instance plus a 5-channel
// instance for the out-of-range address case.
module tb_spi_minion_adapter_mc;

  localparam int NB  = 34;
  localparam int NC  = 4;
  localparam int PW  = 30;
  localparam int NC5 = 5;
  localparam int PW5 = 29;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic            push_en, push_msg_val_wrt, push_msg_val_rd, pull_en;
  logic            pull_msg_val, pull_msg_spc;
  logic [NB-3:0]   push_msg_data, pull_msg_data;
  logic [NC*PW-1:0] recv_msg, send_msg;
  logic [NC-1:0]   recv_val, recv_rdy, send_val, send_rdy, parity;

  logic             b_push_en, b_push_msg_val_wrt, b_push_msg_val_rd, b_pull_en;
  logic             b_pull_msg_val, b_pull_msg_spc;
  logic [NB-3:0]    b_push_msg_data, b_pull_msg_data;
  logic [NC5*PW5-1:0] b_recv_msg, b_send_msg;
  logic [NC5-1:0]   b_recv_val, b_recv_rdy, b_send_val, b_send_rdy, b_parity;

`ifdef SPI_MINION_ADAPTER_MC_ERRCNT_EN
  logic [7:0] err_cnt, b_err_cnt;
  logic       err_flag, b_err_flag;
`endif

  spi_minion_adapter_mc #(.nbits(NB), .num_entries(2), .num_channels(NC)) dut (
    .clk(clk), .reset(reset), .push_en(push_en), .push_msg_val_wrt(push_msg_val_wrt),
    .push_msg_val_rd(push_msg_val_rd), .push_msg_data(push_msg_data), .pull_en(pull_en),
    .pull_msg_val(pull_msg_val), .pull_msg_spc(pull_msg_spc), .pull_msg_data(pull_msg_data),
    .recv_msg(recv_msg), .recv_val(recv_val), .recv_rdy(recv_rdy),
    .send_msg(send_msg), .send_val(send_val), .send_rdy(send_rdy), .parity(parity)
`ifdef SPI_MINION_ADAPTER_MC_ERRCNT_EN
    , .err_cnt(err_cnt), .err_flag(err_flag)
`endif
  );

  spi_minion_adapter_mc #(.nbits(NB), .num_entries(2), .num_channels(NC5)) dut5 (
    .clk(clk), .reset(reset), .push_en(b_push_en), .push_msg_val_wrt(b_push_msg_val_wrt),
    .push_msg_val_rd(b_push_msg_val_rd), .push_msg_data(b_push_msg_data), .pull_en(b_pull_en),
    .pull_msg_val(b_pull_msg_val), .pull_msg_spc(b_pull_msg_spc), .pull_msg_data(b_pull_msg_data),
    .recv_msg(b_recv_msg), .recv_val(b_recv_val), .recv_rdy(b_recv_rdy),
    .send_msg(b_send_msg), .send_val(b_send_val), .send_rdy(b_send_rdy), .parity(b_parity)
`ifdef SPI_MINION_ADAPTER_MC_ERRCNT_EN
    , .err_cnt(b_err_cnt), .err_flag(b_err_flag)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
    $display("check %-14s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Advance to 1ns past the next rising edge and drop all one-shot strobes.
  task automatic cyc();
    @(posedge clk);
    #1;
    push_en = 0; push_msg_val_wrt = 0; push_msg_val_rd = 0; pull_en = 0;
    push_msg_data = '0; recv_val = '0;
    b_push_en = 0; b_push_msg_val_wrt = 0; b_push_msg_val_rd = 0; b_pull_en = 0;
    b_push_msg_data = '0; b_recv_val = '0;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic wr(input logic [1:0] addr, input logic [29:0] payload);
    push_en = 1; push_msg_val_wrt = 1; push_msg_data = {addr, payload};
  endtask

  task automatic rd();
    push_en = 1; push_msg_val_rd = 1; pull_en = 1;
  endtask

  function automatic logic [PW-1:0] smsg(input int ch);
    return send_msg[ch*PW +: PW];
  endfunction

  initial begin
    reset = 1; send_rdy = '0; recv_msg = '0; b_send_rdy = '0; b_recv_msg = '0;
    cyc();
    cyc();
    reset = 0;

    // Reset state, with an empty read strobe applied
    rd();
    settle();
    check("rst_send_val", send_val, 4'b0000);
    check("rst_parity",   parity,   4'b0000);
    check("rst_recv_rdy", recv_rdy, 4'b1111);
    check("rst_spc",      pull_msg_spc, 1'b1);
    check("rst_pull_val", pull_msg_val, 1'b0);
    check("rst_pull_data", pull_msg_data, 32'h0);
    check("rst5_send_val", b_send_val, 5'b00000);
    cyc();

    // Single write to channel 2
    wr(2'd2, 30'h1234);
    settle();
    check("w2_spc", pull_msg_spc, 1'b1);
    cyc();
    settle();
    check("w2_send_val", send_val, 4'b0100);
    check("w2_send_msg", smsg(2), 30'h1234);
    check("w2_parity",   parity,   4'b0100);
    send_rdy = 4'b0100;
    cyc();
    settle();
    check("w2_drained", send_val, 4'b0000);
    send_rdy = '0;

    // Round-robin reads from channels 1 and 3
    recv_val = 4'b1010;
    recv_msg = '0;
    recv_msg[1*PW +: PW] = 30'hAA;
    recv_msg[3*PW +: PW] = 30'h55;
    cyc();
    rd();
    settle();
    check("rd1_val",  pull_msg_val,  1'b1);
    check("rd1_data", pull_msg_data, {2'd1, 30'hAA});
    cyc();
    rd();
    settle();
    check("rd2_val",  pull_msg_val,  1'b1);
    check("rd2_data", pull_msg_data, {2'd3, 30'h55});
    cyc();
    rd();
    settle();
    check("rd3_val",  pull_msg_val,  1'b0);
    check("rd3_data", pull_msg_data, 32'h0);
    cyc();

    // Fill channel 0 with send_rdy low; third write is dropped
    wr(2'd0, 30'h11);
    settle();
    check("f1_spc", pull_msg_spc, 1'b1);
    cyc();
    wr(2'd0, 30'h22);
    settle();
    check("f2_spc", pull_msg_spc, 1'b0);
    cyc();
    wr(2'd0, 30'h33);
    settle();
    check("f3_spc", pull_msg_spc, 1'b0);
    cyc();
    settle();
    check("f_send_val", send_val, 4'b0001);
    check("f_head",     smsg(0),  30'h11);
`ifdef SPI_MINION_ADAPTER_MC_ERRCNT_EN
    check("f_err_cnt",  err_cnt,  8'd1);
    check("f_err_flag", err_flag, 1'b1);
`endif
    send_rdy = 4'b0001;
    cyc();
    settle();
    check("f_second", smsg(0), 30'h22);
    cyc();
    settle();
    check("f_empty", send_val, 4'b0000);
    send_rdy = '0;

    // Out-of-range address on the 5-channel instance, then a valid one
    b_push_en = 1; b_push_msg_val_wrt = 1; b_push_msg_data = {3'd5, 29'h1};
    cyc();
    settle();
    check("c5_bad_addr", b_send_val, 5'b00000);
    b_push_en = 1; b_push_msg_val_wrt = 1; b_push_msg_data = {3'd4, 29'h4};
    cyc();
    settle();
    check("c5_good_val", b_send_val, 5'b10000);
    check("c5_good_msg", b_send_msg[4*PW5 +: PW5], 29'h4);
    cyc();

    // Same-cycle write to ch0 and read from ch2
    recv_val = 4'b0100;
    recv_msg = '0;
    recv_msg[2*PW +: PW] = 30'h7;
    cyc();
    wr(2'd0, 30'h5);
    rd();
    settle();
    check("sc_pull_val",  pull_msg_val,  1'b1);
    check("sc_pull_data", pull_msg_data, {2'd2, 30'h7});
    cyc();
    settle();
    check("sc_send_val", send_val, 4'b0001);
    check("sc_send_msg", smsg(0),  30'h5);

    // Reset with queues partly full; pointer (now 3) must return to 0
    recv_val = 4'b1010;
    recv_msg = '0;
    recv_msg[1*PW +: PW] = 30'h1;
    recv_msg[3*PW +: PW] = 30'h3;
    wr(2'd1, 30'h6);
    cyc();
    settle();
    check("pre_rst_send", send_val, 4'b0011);
    reset = 1;
    cyc();
    reset = 0;
    rd();
    settle();
    check("mr_send_val", send_val, 4'b0000);
    check("mr_pull_val", pull_msg_val, 1'b0);
    cyc();
    recv_val = 4'b1001;
    recv_msg = '0;
    recv_msg[0*PW +: PW] = 30'h9;
    recv_msg[3*PW +: PW] = 30'h3;
    cyc();
    rd();
    settle();
    check("mr_ptr_data", pull_msg_data, {2'd0, 30'h9});
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
